fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch initiator for the pipelined MIPS core. It owns the program counter and drives the word address into the instruction memory, which returns the instruction combinationally. It captures the returned word into the IF/ID pipeline register. It also applies stall, flush and redirect requests from later stages, and flags out-of-range or misaligned fetches.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_WORDS, 4096, instruction-memory depth in 32-bit words. The valid range is IM_BASE to IM_BASE+4*IM_WORDS-1.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1. Asynchronous, active-high. This is already decided.
- stall, input, 1. Hazard stall from ID. Holds both PC and IF/ID.
- flush, input, 1. Clears IF/ID to a bubble.
- redirect, input, 1. npc is valid (branch or jump resolved in ID).
- npc, input, 32, redirect target.
- im_pc, output, 32, fetch address to the instruction memory. It equals pc.
- im_instr, input, 32, instruction word returned combinationally for im_pc.
- pc, output, 32, current PC register.
- if_id_instr, output, 32, latched instruction.
- if_id_pc, output, 32, PC of the latched instruction.
- if_id_pc8, output, 32, if_id_pc+8 (link address).
- if_id_valid, output, 1, IF/ID holds a real fetched slot.
- if_id_adel, output, 1, the latched fetch had an address error.

## Operation
- Next-PC priority at each rising edge:
  - reset
  - stall: hold pc
  - redirect: npc
  - otherwise pc+4
- Simultaneous stall and redirect: stall wins and the redirect is dropped. ID re-asserts it on the cycle it un-stalls.
- flush does not affect pc selection. flush together with redirect is legal and both take effect.
- pc+4 and pc+8 are 32-bit modulo sums. 32'hFFFF_FFFC+4 = 0 with no flag beyond adel.
- Address error (adel_now) is true when any of the following holds:
  - pc[1:0]!=0
  - pc<IM_BASE
  - pc>=IM_BASE+4*IM_WORDS
  The compare is unsigned and 32-bit wide.
- IF/ID update priority at each rising edge:
  - reset
  - flush: instr=0, pc=0, pc8=0, valid=0, adel=0
  - stall: hold all fields
  - otherwise capture:
    - instr = adel_now ? 0 : im_instr
    - pc = pc
    - pc8 = pc+8
    - valid = 1
    - adel = adel_now
- flush and stall together: flush wins.
- Branch delay slot: the instruction fetched in the same cycle that redirect is high is kept, not flushed. Squashing it requires an explicit flush.
- im_pc is always pc, including during stall and address error. The memory is read-only and has no side effects.

## Timing
- Reset values:
  - pc=PC_RESET and im_pc=PC_RESET
  - if_id_instr=0, if_id_pc=0, if_id_pc8=0
  - if_id_valid=0, if_id_adel=0
- reset asserted mid-operation clears everything immediately, without waiting for a clock edge. The first fetch after deassertion is PC_RESET.
- Fetch latency: the word at pc in cycle n appears on if_id_* after edge n+1.
- A redirect sampled at edge n makes pc=npc after edge n. The target's instruction appears in IF/ID after edge n+1.
- While stall is high for k cycles, pc and IF/ID are constant for those k edges. Resume continues from the held pc with no lost or duplicated slot.
- No combinational path from any input to pc or to the if_id_* outputs. im_pc is purely registered.

## Test plan
- Reset and sequential fetch:
  - Stimulus: release reset, IM returns 32'h2408_0001 at 0x3000 and 32'h2409_0002 at 0x3004.
  - Response: if_id_pc=0x3000 then 0x3004, if_id_pc8=0x3008 then 0x300C, valid=1, adel=0.
- Redirect:
  - Stimulus: redirect=1, npc=0x3040 at pc=0x3008.
  - Response: the 0x3008 slot is latched, next pc=0x3040, and if_id_pc=0x3040 one edge later.
- Stall against redirect:
  - Stimulus: stall=1 and redirect=1 (npc=0x3100) for 2 cycles at pc=0x3010, then stall=0 and redirect=1.
  - Response: pc holds 0x3010 for both cycles, then becomes 0x3100. IF/ID is unchanged during the stall.
- Flush priority:
  - Stimulus: flush=1 together with stall=1.
  - Response: if_id_instr=0, if_id_pc=0, valid=0, and pc is held.
- Address error:
  - Stimulus: npc=0x3002, then npc=0x7000 with IM_WORDS=4096.
  - Response: each slot is latched with adel=1, instr=0, valid=1. pc advances to 0x3006 and 0x7004 respectively.
- Asynchronous reset mid-run:
  - Stimulus: assert reset between clock edges at pc=0x3020.
  - Response: pc=0x3000 and valid=0 immediately. Fetch resumes at 0x3000 after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// fills the IF/ID register, honouring stall, flush and redirect from later stages.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] npc,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8,
  output logic        if_id_valid,
  output logic        if_id_adel
);

  localparam logic [31:0] IM_LIMIT = IM_BASE + 32'(4 * IM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;
  logic        adel_q, adel_d;
  logic        adel_now;

  assign adel_now = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q >= IM_LIMIT);

  // A stalled redirect is dropped; ID re-asserts it once the stall clears.
  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      if (redirect) pc_d = npc;
      else          pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    instr_d = instr_q;
    ipc_d   = ipc_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    adel_d  = adel_q;
    if (flush) begin
      instr_d = '0;
      ipc_d   = '0;
      pc8_d   = '0;
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end else if (!stall) begin
      instr_d = adel_now ? '0 : im_instr;
      ipc_d   = pc_q;
      pc8_d   = pc_q + 32'd8;
      valid_d = 1'b1;
      adel_d  = adel_now;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      instr_q <= '0;
      ipc_q   <= '0;
      pc8_q   <= '0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
    end
  end

  assign pc          = pc_q;
  assign im_pc       = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign if_id_pc8   = pc8_q;
  assign if_id_valid = valid_q;
  assign if_id_adel  = adel_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized stall/flush/redirect/reset traffic checked every cycle against a model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] npc = '0;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc8;
  logic        if_id_valid;
  logic        if_id_adel;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_RESET(32'h0000_3000),
    .IM_BASE (32'h0000_3000),
    .IM_WORDS(4096)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .redirect   (redirect),
    .npc        (npc),
    .im_pc      (im_pc),
    .im_instr   (im_instr),
    .pc         (pc),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_pc8  (if_id_pc8),
    .if_id_valid(if_id_valid),
    .if_id_adel (if_id_adel)
  );

  // Instruction memory contents: two fixed words, everything else an address hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0001;
    if (a == 32'h0000_3004) return 32'h2409_0002;
    return {a[15:0] ^ 16'hBEEF, a[31:16] + a[7:0] + 16'h1234};
  endfunction

  assign im_instr = mem_word(im_pc);

  // Legal fetch window is word-aligned 0x3000..0x6FFF for these parameters.
  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one slot per edge, described by what the slot must contain.
  logic [31:0] m_pc = 32'h3000;
  logic [31:0] m_instr = '0, m_ipc = '0, m_pc8 = '0;
  logic        m_valid = 1'b0, m_adel = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 32'h3000;
      {m_instr, m_ipc, m_pc8} <= '0;
      m_valid <= 1'b0;
      m_adel  <= 1'b0;
    end else begin
      if (flush) begin
        {m_instr, m_ipc, m_pc8} <= '0;
        m_valid <= 1'b0;
        m_adel  <= 1'b0;
      end else if (!stall) begin
        m_instr <= bad_addr(m_pc) ? 32'h0 : mem_word(m_pc);
        m_ipc   <= m_pc;
        m_pc8   <= m_pc + 32'd8;
        m_valid <= 1'b1;
        m_adel  <= bad_addr(m_pc);
      end
      if (!stall) m_pc <= redirect ? npc : m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("im_pc", im_pc, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_pc8", if_id_pc8, m_pc8);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("if_id_adel", {31'b0, if_id_adel}, {31'b0, m_adel});
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_ifpc", if_id_pc, 32'h0);
    reset = 1'b0;

    // Sequential fetch
    edge1();
    chk("seq0_ifpc", if_id_pc, 32'h3000);
    chk("seq0_instr", if_id_instr, 32'h2408_0001);
    chk("seq0_pc8", if_id_pc8, 32'h3008);
    chk("seq0_valid", {31'b0, if_id_valid}, 32'h1);
    edge1();
    chk("seq1_ifpc", if_id_pc, 32'h3004);
    chk("seq1_instr", if_id_instr, 32'h2409_0002);
    chk("seq1_pc8", if_id_pc8, 32'h300C);
    chk("seq1_pc", pc, 32'h3008);

    // Redirect keeps the delay slot
    redirect = 1'b1; npc = 32'h3040;
    edge1();
    chk("redir_slot", if_id_pc, 32'h3008);
    chk("redir_pc", pc, 32'h3040);
    redirect = 1'b0;
    edge1();
    chk("redir_tgt", if_id_pc, 32'h3040);

    // Stall beats redirect
    redirect = 1'b1; npc = 32'h3010;
    edge1();
    chk("pre_stall_pc", pc, 32'h3010);
    stall = 1'b1; npc = 32'h3100;
    edge1();
    chk("stall1_pc", pc, 32'h3010);
    chk("stall1_ifpc", if_id_pc, 32'h3044);
    edge1();
    chk("stall2_pc", pc, 32'h3010);
    chk("stall2_ifpc", if_id_pc, 32'h3044);
    stall = 1'b0;
    edge1();
    chk("unstall_pc", pc, 32'h3100);
    chk("unstall_ifpc", if_id_pc, 32'h3010);
    redirect = 1'b0;

    // Flush beats stall
    flush = 1'b1; stall = 1'b1;
    edge1();
    chk("flush_pc", pc, 32'h3100);
    chk("flush_ifpc", if_id_pc, 32'h0);
    chk("flush_instr", if_id_instr, 32'h0);
    chk("flush_valid", {31'b0, if_id_valid}, 32'h0);
    flush = 1'b0; stall = 1'b0;
    edge1();
    chk("post_flush_ifpc", if_id_pc, 32'h3100);

    // Address errors: misaligned, above range, and wraparound
    redirect = 1'b1; npc = 32'h3002;
    edge1();
    redirect = 1'b0;
    edge1();
    chk("mis_ifpc", if_id_pc, 32'h3002);
    chk("mis_adel", {31'b0, if_id_adel}, 32'h1);
    chk("mis_instr", if_id_instr, 32'h0);
    chk("mis_valid", {31'b0, if_id_valid}, 32'h1);
    chk("mis_pc", pc, 32'h3006);
    redirect = 1'b1; npc = 32'h7000;
    edge1();
    redirect = 1'b0;
    edge1();
    chk("oor_adel", {31'b0, if_id_adel}, 32'h1);
    chk("oor_instr", if_id_instr, 32'h0);
    chk("oor_pc", pc, 32'h7004);
    redirect = 1'b1; npc = 32'h2FFC;
    edge1();
    redirect = 1'b0;
    edge1();
    chk("low_adel", {31'b0, if_id_adel}, 32'h1);
    redirect = 1'b1; npc = 32'h6FFC;
    edge1();
    redirect = 1'b0;
    edge1();
    chk("top_adel", {31'b0, if_id_adel}, 32'h0);
    redirect = 1'b1; npc = 32'hFFFF_FFFC;
    edge1();
    redirect = 1'b0;
    edge1();
    chk("wrap_pc8", if_id_pc8, 32'h4);
    chk("wrap_pc", pc, 32'h0);

    // Asynchronous reset between edges
    redirect = 1'b1; npc = 32'h3020;
    edge1();
    redirect = 1'b0;
    chk("pre_rst_pc", pc, 32'h3020);
    #2 reset = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h3000);
    chk("arst_valid", {31'b0, if_id_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    edge1();
    chk("arst_resume_ifpc", if_id_pc, 32'h3000);
    chk("arst_resume_pc", pc, 32'h3004);

    // Randomized traffic; the model and per-cycle compare do the checking
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      reset    = 1'b0;
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 5) == 0);
      redirect = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 9))
        0:       npc = $urandom;
        1:       npc = 32'h3000 + ($urandom_range(0, 4095) * 4) + $urandom_range(1, 3);
        2:       npc = 32'h6FF0 + $urandom_range(0, 7) * 4;
        default: npc = 32'h3000 + $urandom_range(0, 4095) * 4;
      endcase
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
